// File: rtl/output_reg_tx.sv
// output_reg_tx: FIFO-buffered word transmitter that presents data_out, then a registered srdyo strobe.
// Define OUTPUT_REG_TX_PARITY_EN to add the data_par output (XOR reduction of data_out).
module output_reg_tx #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int HIGH_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              srdyo,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_level
`ifdef OUTPUT_REG_TX_PARITY_EN
  ,
  output logic              data_par
`endif
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] SETUP_M1 = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HIGH_M1  = 8'(HIGH_CYC - 1);
  localparam logic [7:0] HOLD_M1  = 8'(HOLD_CYC - 1);
  if (SETUP_CYC < 1 || SETUP_CYC > 255 || HIGH_CYC < 1 || HIGH_CYC > 255 ||
      HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_param
    $error("output_reg_tx: SETUP_CYC, HIGH_CYC and HOLD_CYC must be in 1..255");
  end
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_q, rd_q;
  logic [ADDR_W:0]   lvl_q;
  logic [1:0]        st_q, st_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q;
  logic              srdyo_q, rdy_q, push, load, done;
  // rdy_q keeps din_ready low during reset and for nothing else
  assign din_ready  = rdy_q && (lvl_q != (ADDR_W+1)'(DEPTH));
  assign push       = din_valid && din_ready;
  assign done       = cnt_q == 8'd0;
  assign load       = (lvl_q != '0) && (st_q == IDLE || (st_q == HOLD && done));
  assign data_out   = dout_q;
  assign srdyo      = srdyo_q;
  assign busy       = (st_q != IDLE) || (lvl_q != '0);
  assign fifo_level = lvl_q;
  always_comb begin
    st_d  = st_q;
    cnt_d = done ? cnt_q : cnt_q - 8'd1;
    if (load) begin
      st_d  = SETUP;
      cnt_d = SETUP_M1;
    end else if (done) begin
      st_d  = st_q == SETUP ? STROBE : st_q == STROBE ? HOLD : IDLE;
      cnt_d = st_q == SETUP ? HIGH_M1 : st_q == STROBE ? HOLD_M1 : 8'd0;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
`ifdef OUTPUT_REG_TX_PARITY_EN
  logic par_q;
  assign data_par = par_q;
`endif
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      rdy_q   <= 1'b0;
      st_q    <= IDLE;
      cnt_q   <= 8'd0;
      srdyo_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      dout_q  <= '0;
`ifdef OUTPUT_REG_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      rdy_q   <= 1'b1;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      srdyo_q <= st_d == STROBE;
      lvl_q   <= lvl_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(load);
      if (push) wr_q <= wr_q + ADDR_W'(1);
      if (load) begin
        rd_q   <= rd_q + ADDR_W'(1);
        dout_q <= mem_q[rd_q];
`ifdef OUTPUT_REG_TX_PARITY_EN
        par_q  <= ^mem_q[rd_q];
`endif
      end
    end
  end
endmodule

// File: tb/tb_output_reg_tx.sv
// tb_output_reg_tx: directed bench for output_reg_tx (default and SETUP=3/HIGH=1/HOLD=2 instances).
module tb_output_reg_tx;
  logic        clk, rst_n;
  logic [31:0] din, v_din, data_out, v_dout;
  logic        din_valid, v_valid, din_ready, v_ready, srdyo, v_srdyo, busy, v_busy;
  logic [2:0]  fifo_level, v_level;
`ifdef OUTPUT_REG_TX_PARITY_EN
  logic        data_par, v_par;
`endif
  int          errors, checks, rise_cnt, since_chg, since_low;
  logic [31:0] cap[$];
  time         rise_t[$];
  logic [31:0] p_dout;
  logic        p_srdyo;

  output_reg_tx dut (
    .clk(clk), .GlobalReset(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .data_out(data_out), .srdyo(srdyo), .busy(busy), .fifo_level(fifo_level)
`ifdef OUTPUT_REG_TX_PARITY_EN
    , .data_par(data_par)
`endif
  );

  output_reg_tx #(.SETUP_CYC(3), .HIGH_CYC(1), .HOLD_CYC(2)) dut2 (
    .clk(clk), .GlobalReset(rst_n), .din(v_din), .din_valid(v_valid), .din_ready(v_ready),
    .data_out(v_dout), .srdyo(v_srdyo), .busy(v_busy), .fifo_level(v_level)
`ifdef OUTPUT_REG_TX_PARITY_EN
    , .data_par(v_par)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Downstream capture register model
  always @(posedge srdyo) if (rst_n) begin
    rise_cnt++;
    cap.push_back(data_out);
    rise_t.push_back($time);
  end

  // Setup/hold monitor on the default instance
  always @(negedge clk) begin
    if (!rst_n) begin
      since_chg = 100;
      since_low = 100;
    end else begin
      if (srdyo && !p_srdyo) begin
        checks++;
        if (data_out !== p_dout || since_chg < 1) begin
          errors++;
          $display("FAIL strobe_setup: data_out %h prev %h cycles_since_change %0d required >=1", data_out, p_dout, since_chg);
        end
      end
      if (data_out !== p_dout) begin
        checks++;
        if (srdyo || since_low < 1) begin
          errors++;
          $display("FAIL data_hold: data_out changed with srdyo=%b low_cycles=%0d required srdyo=0 and >=1", srdyo, since_low);
        end
      end
      since_chg = (data_out !== p_dout) ? 1 : since_chg + 1;
      since_low = srdyo ? 0 : since_low + 1;
    end
    p_dout  = data_out;
    p_srdyo = srdyo;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h exp 0", data_out); end
    checks++; if (srdyo !== 1'b0) begin errors++; $display("FAIL reset_srdyo: got %b exp 0", srdyo); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %b exp 0", din_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", fifo_level); end
`ifdef OUTPUT_REG_TX_PARITY_EN
    checks++; if (data_par !== 1'b0) begin errors++; $display("FAIL reset_par: got %b exp 0", data_par); end
`endif
    rst_n = 1;
    @(negedge clk);
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL release_din_ready: got %b exp 1", din_ready); end
  endtask

  task automatic test_single;
    logic [4:0] es, eb;
    int r0;
    es = 5'b00110;
    eb = 5'b01111;
    r0 = rise_cnt;
    din = 32'hDEADBEEF;
    din_valid = 1;
    @(negedge clk);
    din_valid = 0;
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level0: got %0d exp 1", fifo_level); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data e%0d: got %h exp deadbeef", k, data_out); end
      checks++; if (srdyo !== es[k-1]) begin errors++; $display("FAIL single_srdyo e%0d: got %b exp %b", k, srdyo, es[k-1]); end
      checks++; if (busy !== eb[k-1]) begin errors++; $display("FAIL single_busy e%0d: got %b exp %b", k, busy, eb[k-1]); end
    end
    checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL single_rises: got %0d exp 1", rise_cnt - r0); end
    checks++; if (cap.size() == 0 || cap[cap.size()-1] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_capture: size %0d exp last deadbeef", cap.size()); end
  endtask

  task automatic test_burst;
    logic go, saw_full;
    int n;
    cap.delete();
    rise_t.delete();
    saw_full = 0;
    n = 1;
    din = 1;
    din_valid = 1;
    for (int c = 0; c < 100 && (din_valid || busy); c++) begin
      go = din_ready;
      if (fifo_level == 3'd4) begin
        saw_full = 1;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL burst_full_ready: got %b exp 0", din_ready); end
      end
      @(negedge clk);
      if (go) begin
        if (n == 6) din_valid = 0;
        else begin
          n++;
          din = n;
        end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_timeout: busy %b exp 0", busy); end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL burst_reached_full: got %b exp 1", saw_full); end
    checks++; if (cap.size() != 6) begin errors++; $display("FAIL burst_count: got %0d exp 6", cap.size()); end
    for (int i = 0; i < cap.size() && i < 6; i++) begin
      checks++; if (cap[i] !== 32'(i + 1)) begin errors++; $display("FAIL burst_word%0d: got %h exp %h", i, cap[i], i + 1); end
    end
    for (int i = 1; i < rise_t.size(); i++) begin
      checks++; if (rise_t[i] - rise_t[i-1] != 40) begin errors++; $display("FAIL burst_period%0d: got %0t exp 40", i, rise_t[i] - rise_t[i-1]); end
    end
  endtask

  task automatic test_reset_mid;
    int r0;
    din = 32'hA0A0_0001;
    din_valid = 1;
    @(negedge clk);
    din = 32'hA0A0_0002;
    @(negedge clk);
    din = 32'hA0A0_0003;
    @(negedge clk);
    din_valid = 0;
    for (int c = 0; c < 10 && !srdyo; c++) @(negedge clk);
    checks++; if (srdyo !== 1'b1) begin errors++; $display("FAIL mid_strobe_seen: got %b exp 1", srdyo); end
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL mid_queued: got %0d exp 2", fifo_level); end
    r0 = rise_cnt;
    #2 rst_n = 0;
    #1;
    checks++; if (srdyo !== 1'b0) begin errors++; $display("FAIL mid_srdyo: got %b exp 0", srdyo); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL mid_data: got %h exp 0", data_out); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level: got %0d exp 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b exp 0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    checks++; if (rise_cnt != r0) begin errors++; $display("FAIL mid_no_strobe: rises %0d exp %0d", rise_cnt, r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle_busy: got %b exp 0", busy); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL mid_idle_data: got %h exp 0", data_out); end
  endtask

  task automatic test_variant;
    logic [12:0] vec;
    logic [31:0] ed;
    vec = '0;
    v_din = 32'h1111_1111;
    v_valid = 1;
    @(negedge clk);
    v_din = 32'h2222_2222;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      v_valid = 0;
      vec[k-1] = v_srdyo;
      ed = (k < 7) ? 32'h1111_1111 : 32'h2222_2222;
      checks++; if (v_dout !== ed) begin errors++; $display("FAIL var_data e%0d: got %h exp %h", k, v_dout, ed); end
      checks++; if (v_busy !== (k < 13)) begin errors++; $display("FAIL var_busy e%0d: got %b exp %b", k, v_busy, k < 13); end
    end
    checks++; if (vec !== 13'h208) begin errors++; $display("FAIL var_srdyo_pattern: got %b exp %b", vec, 13'h208); end
  endtask

`ifdef OUTPUT_REG_TX_PARITY_EN
  task automatic test_parity;
    logic [31:0] w [2];
    logic        ep [2];
    w[0] = 32'h7; ep[0] = 1'b1;
    w[1] = 32'h3; ep[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      din = w[j];
      din_valid = 1;
      @(negedge clk);
      din_valid = 0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        checks++; if (data_par !== ep[j]) begin errors++; $display("FAIL parity w%0d e%0d: got %b exp %b", j, k, data_par, ep[j]); end
      end
      for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    end
  endtask
`endif

  initial begin
    errors = 0; checks = 0; rise_cnt = 0;
    din = 0; v_din = 0; din_valid = 0; v_valid = 0;
    test_reset();
    test_single();
    test_burst();
    test_reset_mid();
    test_variant();
`ifdef OUTPUT_REG_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
